risc_spm_boot_loader: RTL and testbench



---
 rtl/risc_spm_boot_loader_if.sv | 26 ++
 rtl/risc_spm_boot_loader.sv | 156 +++++++++++++++
 tb/tb_risc_spm_boot_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/risc_spm_boot_loader_if.sv
// Stream and RAM-write bundle for the RISC_SPM boot loader.
//   in_data/in_valid/in_ready : framed byte stream, valid/ready handshake
//   mem_we/mem_addr/mem_wdata : single RAM write port, one byte per strobe
// slave  : used by the loader (consumes stream, drives RAM port)
// master : used by the stream source / RAM model side
interface risc_spm_boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/risc_spm_boot_loader.sv
// Program-load stage for RISC_SPM. Parses frames
//   SYNC_BYTE, START_ADDR, COUNT, COUNT data bytes (0 = 2^DATA_W), CSUM
// and writes the payload through the RAM write port, holding the CPU in
// reset until a frame with a good checksum has been loaded.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   bus        risc_spm_boot_loader_if.slave (stream in, RAM write out)
//   cpu_rst_n  reset to RISC_SPM, active-low
//   busy       frame in progress (ADDR..CSUM)
//   done       last frame loaded successfully (sticky)
//   err        last frame failed (sticky until next SYNC_BYTE or rst)
// Optional feature: define BOOT_LOADER_TIMEOUT_EN to abort a frame into
// ERR after TIMEOUT_CYC idle cycles between bytes.
module risc_spm_boot_loader #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = 8'hA5,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  risc_spm_boot_loader_if.slave   bus,
  output logic                    cpu_rst_n,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CNT, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic              ready_en;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W:0]   cnt;       // one extra bit so COUNT==0 can hold 2^DATA_W
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_nxt;
  logic              acc;
  logic              is_sync;
  logic              tmo_hit;

  assign acc     = bus.in_valid && bus.in_ready;
  assign is_sync = (bus.in_data == SYNC_BYTE);
  assign sum_nxt = sum + bus.in_data;

`ifdef BOOT_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Idle-gap counter; the TIMEOUT_CYC-th consecutive idle busy cycle aborts.
  assign tmo_hit = busy && !acc && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst || !busy || acc) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (acc && is_sync) state_nxt = S_ADDR;
      S_ADDR: if (acc) state_nxt = S_CNT;
      S_CNT:  if (acc) state_nxt = S_DATA;
      S_DATA: if (acc && cnt == (DATA_W+1)'(1)) state_nxt = S_CSUM;
      S_CSUM: if (acc) state_nxt = (sum_nxt == '0) ? S_DONE : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_hit) state_nxt = S_ERR;
  end

  // Output logic
  always_comb begin
    busy         = (state == S_ADDR) || (state == S_CNT) ||
                   (state == S_DATA) || (state == S_CSUM);
    bus.in_ready = ready_en;
  end

  // Datapath: pointer, count, checksum, RAM port and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_en      <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      ptr           <= '0;
      cnt           <= '0;
      sum           <= '0;
      cpu_rst_n     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Stall one cycle after the checksum byte while the result resolves.
      ready_en   <= !(state == S_CSUM && acc);
      bus.mem_we <= 1'b0;
      // Release lands one cycle after entering DONE.
      if (state == S_DONE) cpu_rst_n <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (acc && is_sync) begin
            sum       <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
          end
        end
        S_ADDR: begin
          if (acc) begin
            ptr <= ADDR_W'(bus.in_data);
            sum <= sum_nxt;
          end
        end
        S_CNT: begin
          if (acc) begin
            cnt <= {(bus.in_data == '0), bus.in_data};
            sum <= sum_nxt;
          end
        end
        S_DATA: begin
          if (acc) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= bus.in_data;
            ptr           <= ptr + 1'b1;
            cnt           <= cnt - 1'b1;
            sum           <= sum_nxt;
          end
        end
        S_CSUM: begin
          if (acc) begin
            sum <= sum_nxt;
            if (sum_nxt == '0) done <= 1'b1;
            else               err  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (tmo_hit) begin
        err       <= 1'b1;
        cpu_rst_n <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_risc_spm_boot_loader.sv
module tb_risc_spm_boot_loader;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_rst_n, busy, done, err;
  always #5 clk = ~clk;

  risc_spm_boot_loader_if #(.ADDR_W(8), .DATA_W(8)) bif();

  risc_spm_boot_loader #(
    .ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif.slave),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Present one byte, wait (bounded) for in_ready, drop valid after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit rdy;
    int t = 0;
    if (gap) @(posedge clk);
    @(negedge clk);
    bif.in_data  = b;
    bif.in_valid = 1'b1;
    rdy = bif.in_ready;
    while (!rdy && t < 20) begin
      @(negedge clk);
      rdy = bif.in_ready;
      t++;
    end
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    chk("in_ready within bound", {31'b0, rdy}, 32'd1);
  endtask

  logic [7:0] fr[$];

  // Drive fr[] (pre leading garbage bytes) and check every beat's write/no-write.
  task automatic run_frame(input int pre, input bit gap, input bit exp_done,
                           input bit exp_err, input string nm);
    int cnt = 0;
    logic [7:0] start = 8'h00;
    for (int i = 0; i < fr.size(); i++) begin
      int p = i - pre;
      send_byte(fr[i], gap);
      if (p >= 3 && p < 3 + cnt)
        chk({nm, " write"}, {15'b0, bif.mem_we, bif.mem_addr, bif.mem_wdata},
            {15'b0, 1'b1, start + 8'(p - 3), fr[i]});
      else
        chk({nm, " no write"}, {31'b0, bif.mem_we}, 32'd0);
      if (p == 0) begin
        chk({nm, " sync busy"}, {31'b0, busy}, 32'd1);
        chk({nm, " sync flags"}, {29'b0, done, err, cpu_rst_n}, 32'd0);
      end
      if (p == 1) start = fr[i];
      if (p == 2) cnt = (fr[i] == 8'h00) ? 256 : int'(fr[i]);
    end
    chk({nm, " resolve ready/busy/cpu"}, {29'b0, bif.in_ready, busy, cpu_rst_n}, 32'd0);
    chk({nm, " resolve done/err"}, {30'b0, done, err}, {30'b0, exp_done, exp_err});
    @(posedge clk);
    #1;
    chk({nm, " cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, exp_done});
    chk({nm, " final ready/done/err"}, {29'b0, bif.in_ready, done, err},
        {29'b0, 1'b1, exp_done, exp_err});
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " ready/we/cpu/busy/done/err"},
        {26'b0, bif.in_ready, bif.mem_we, cpu_rst_n, busy, done, err}, 32'd0);
    chk({nm, " addr/wdata"}, {16'b0, bif.mem_addr, bif.mem_wdata}, 32'd0);
  endtask

  typedef struct {
    logic [0:11][7:0] b;
    int               n;
    int               pre;
    bit               gap;
    bit               exp_done;
    bit               exp_err;
    string            name;
  } vec_t;

  vec_t vt[5];

  initial begin
    bif.in_data  = 8'h00;
    bif.in_valid = 1'b0;

    vt[0].b = {8'hA5, 8'h80, 8'h04, 8'h06, 8'h01, 8'h0A, 8'h05, 8'h66, 32'h0};
    vt[0].n = 8; vt[0].pre = 0; vt[0].gap = 0; vt[0].exp_done = 1; vt[0].exp_err = 0;
    vt[0].name = "good";
    vt[1].b = {8'hA5, 8'h80, 8'h04, 8'h06, 8'h01, 8'h0A, 8'h05, 8'h67, 32'h0};
    vt[1].n = 8; vt[1].pre = 0; vt[1].gap = 0; vt[1].exp_done = 0; vt[1].exp_err = 1;
    vt[1].name = "bad_csum";
    vt[2] = vt[0];
    vt[2].name = "good_after_bad";
    vt[3].b = {8'hA5, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h99, 40'h0};
    vt[3].n = 7; vt[3].pre = 0; vt[3].gap = 0; vt[3].exp_done = 1; vt[3].exp_err = 0;
    vt[3].name = "wrap";
    // Garbage before sync, valid toggling, SYNC value inside the payload.
    vt[4].b = {8'h00, 8'hFF, 8'hA5, 8'h10, 8'h02, 8'hA5, 8'h3C, 8'h0D, 32'h0};
    vt[4].n = 8; vt[4].pre = 2; vt[4].gap = 1; vt[4].exp_done = 1; vt[4].exp_err = 0;
    vt[4].name = "garbage_gap";

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      fr.delete();
      for (int j = 0; j < vt[k].n; j++) fr.push_back(vt[k].b[j]);
      run_frame(vt[k].pre, vt[k].gap, vt[k].exp_done, vt[k].exp_err, vt[k].name);
    end

    // COUNT==0 loads 256 bytes; sum(0..255) mod 256 = 80, so CSUM = 80.
    fr.delete();
    fr.push_back(8'hA5); fr.push_back(8'h00); fr.push_back(8'h00);
    for (int j = 0; j < 256; j++) fr.push_back(8'(j));
    fr.push_back(8'h80);
    run_frame(0, 0, 1, 0, "count256");

    // Reset after the 2nd data byte, then a clean frame.
    send_byte(8'hA5, 0);
    send_byte(8'h40, 0);
    send_byte(8'h05, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    chk("pre-reset write", {15'b0, bif.mem_we, bif.mem_addr, bif.mem_wdata},
        {15'b0, 1'b1, 8'h41, 8'h02});
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("mid-frame reset");
    @(negedge clk);
    rst = 1'b1;
    fr.delete();
    fr.push_back(8'hA5); fr.push_back(8'h40); fr.push_back(8'h02);
    fr.push_back(8'h01); fr.push_back(8'h02); fr.push_back(8'hBB);
    run_frame(0, 0, 1, 0, "after_reset");

    // Long stall after COUNT.
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    repeat (TMO) @(posedge clk);
    #1;
`ifdef BOOT_LOADER_TIMEOUT_EN
    chk("timeout err/busy/cpu", {29'b0, err, busy, cpu_rst_n}, {29'b0, 1'b1, 1'b0, 1'b0});
    send_byte(8'h07, 0);
    chk("timeout discard", {30'b0, bif.mem_we, err}, {30'b0, 1'b0, 1'b1});
`else
    chk("stall err/busy", {30'b0, err, busy}, {30'b0, 1'b0, 1'b1});
    send_byte(8'h07, 0);
    chk("stall write", {15'b0, bif.mem_we, bif.mem_addr, bif.mem_wdata},
        {15'b0, 1'b1, 8'h20, 8'h07});
    send_byte(8'hD8, 0);
    @(posedge clk);
    #1;
    chk("stall done/err/cpu", {29'b0, done, err, cpu_rst_n}, {29'b0, 1'b1, 1'b0, 1'b1});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
